// File: rtl/mips_lsu.sv
// Load/store unit: turns byte/half/word/LWL/LWR loads and SB/SH/SW stores into
// word-aligned accesses on a word-only RAM, with read-modify-write for sub-word stores.
module mips_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_rt,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       data_address,
  output logic              data_read,
  output logic              data_write,
  output logic [31:0]       data_writedata,
  input  logic [31:0]       data_readdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    STORE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t      state_r;
  logic [2:0]  op_r;
  logic [1:0]  lo_r;
  logic [31:0] wdata_r;
  logic [31:0] rt_r;
  logic        req_ready_r;
  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_err_r;
  logic [31:0] data_address_r;
  logic        data_read_r;
  logic        data_write_r;
  logic [31:0] data_writedata_r;
  logic [31:0] aligned_s;

  assign aligned_s = 32'({req_addr[ADDR_W-1:2], 2'b00});

  function automatic logic req_err(input logic write, input logic [2:0] op, input logic [1:0] lo);
    logic e;
    if (write) begin
      case (op)
        3'b000:  e = 1'b0;
        3'b001:  e = lo[0];
        3'b011:  e = |lo;
        default: e = 1'b1;
      endcase
    end else begin
      case (op)
        3'b000, 3'b100, 3'b010, 3'b110: e = 1'b0;
        3'b001, 3'b101:                 e = lo[0];
        3'b011:                         e = |lo;
        default:                        e = 1'b1;
      endcase
    end
    return e;
  endfunction

  // Lane selection and LWL/LWR merge with the old rt value.
  function automatic logic [31:0] load_fmt(input logic [2:0] op, input logic [1:0] b,
                                           input logic [31:0] mem, input logic [31:0] rt);
    logic [7:0]  by;
    logic [15:0] hw;
    logic [4:0]  shl;
    logic [4:0]  shr;
    logic [31:0] res;
    by  = mem[{b, 3'b000} +: 8];
    hw  = b[1] ? mem[31:16] : mem[15:0];
    shl = {~b, 3'b000};
    shr = {b, 3'b000};
    case (op)
      3'b000:  res = {{24{by[7]}}, by};
      3'b100:  res = {24'h000000, by};
      3'b001:  res = {{16{hw[15]}}, hw};
      3'b101:  res = {16'h0000, hw};
      3'b011:  res = mem;
      3'b010:  res = (mem << shl) | (rt & ((32'h0000_0001 << shl) - 32'h0000_0001));
      3'b110:  res = (mem >> shr) | (rt & ~(32'hFFFF_FFFF >> shr));
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] op, input logic [1:0] b,
                                              input logic [31:0] mem, input logic [31:0] wd);
    logic [31:0] res;
    res = mem;
    case (op)
      3'b000: res[{b, 3'b000} +: 8] = wd[7:0];
      3'b001: begin
        if (b[1]) res[31:16] = wd[15:0];
        else      res[15:0]  = wd[15:0];
      end
      default: res = wd;
    endcase
    return res;
  endfunction

  // Control FSM; every output is a register so reset clears strobes immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r          <= IDLE;
      op_r             <= 3'b000;
      lo_r             <= 2'b00;
      wdata_r          <= 32'h0000_0000;
      rt_r             <= 32'h0000_0000;
      req_ready_r      <= 1'b1;
      resp_valid_r     <= 1'b0;
      resp_rdata_r     <= 32'h0000_0000;
      resp_err_r       <= 1'b0;
      data_address_r   <= 32'h0000_0000;
      data_read_r      <= 1'b0;
      data_write_r     <= 1'b0;
      data_writedata_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready_r) begin
            op_r        <= req_op;
            lo_r        <= req_addr[1:0];
            wdata_r     <= req_wdata;
            rt_r        <= req_rt;
            req_ready_r <= 1'b0;
            if (req_err(req_write, req_op, req_addr[1:0])) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'h0000_0000;
            end else if (!req_write) begin
              state_r        <= LOAD;
              data_read_r    <= 1'b1;
              data_address_r <= aligned_s;
            end else if (req_op == 3'b011) begin
              state_r          <= STORE;
              data_write_r     <= 1'b1;
              data_writedata_r <= req_wdata;
              data_address_r   <= aligned_s;
            end else begin
              state_r        <= RMW_RD;
              data_read_r    <= 1'b1;
              data_address_r <= aligned_s;
            end
          end
        end
        LOAD: begin
          data_read_r  <= 1'b0;
          resp_rdata_r <= load_fmt(op_r, lo_r, data_readdata, rt_r);
          resp_err_r   <= 1'b0;
          resp_valid_r <= 1'b1;
          state_r      <= RESP;
        end
        RMW_RD: begin
          data_read_r      <= 1'b0;
          data_write_r     <= 1'b1;
          data_writedata_r <= store_merge(op_r, lo_r, data_readdata, wdata_r);
          state_r          <= STORE;
        end
        STORE: begin
          data_write_r <= 1'b0;
          resp_rdata_r <= 32'h0000_0000;
          resp_err_r   <= 1'b0;
          resp_valid_r <= 1'b1;
          state_r      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            req_ready_r  <= 1'b1;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          data_read_r  <= 1'b0;
          data_write_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_r;
  assign resp_valid     = resp_valid_r;
  assign resp_rdata     = resp_rdata_r;
  assign resp_err       = resp_err_r;
  assign data_address   = data_address_r;
  assign data_read      = data_read_r;
  assign data_write     = data_write_r;
  assign data_writedata = data_writedata_r;

endmodule

// File: tb/tb_mips_lsu.sv
// Scoreboard bench for mips_lsu: a byte-level reference model predicts each response,
// and a negedge monitor compares responses, latency and RAM strobes.
module tb_mips_lsu;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_rt;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata, data_address, data_writedata, data_readdata;
  logic        data_read, data_write;

  always #5 clk = ~clk;

  mips_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rt(req_rt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .data_address(data_address), .data_read(data_read),
    .data_write(data_write), .data_writedata(data_writedata), .data_readdata(data_readdata)
  );

  logic [31:0] ram [16];
  logic [31:0] ref_mem [16];
  assign data_readdata = ram[data_address[5:2]];
  always @(posedge clk) if (data_write) ram[data_address[5:2]] <= data_writedata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
    int          nrd;
    int          nwr;
    logic        is_store;
    logic [3:0]  idx;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;
  bit          in_resp = 1'b0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  function void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: operates on bytes of the tracked memory image.
  function automatic exp_t model(input logic w, input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rt);
    exp_t e;
    int b, size, sh;
    logic [31:0] m, v;
    logic legal;
    b = int'(addr[1:0]);
    e.idx = addr[5:2];
    m = ref_mem[e.idx];
    size = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    legal = w ? (op == 3'd0 || op == 3'd1 || op == 3'd3) : (op != 3'd7);
    if (!(op == 3'd2 || op == 3'd6) && (b % size) != 0) legal = 1'b0;
    e.rdata = 32'h0; e.err = !legal; e.nrd = 0; e.nwr = 0; e.is_store = w; e.acc = 0;
    if (legal && w) begin
      e.nwr = 1;
      if (size < 4) e.nrd = 1;
      for (int i = 0; i < size; i++) m[8*(b+i) +: 8] = wd[8*i +: 8];
      ref_mem[e.idx] = m;
    end else if (legal) begin
      e.nrd = 1;
      v = 32'h0;
      case (op)
        3'd0, 3'd4: begin
          v = (m >> (8*b)) & 32'hFF;
          if (op == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
        end
        3'd1, 3'd5: begin
          v = (m >> (8*b)) & 32'hFFFF;
          if (op == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        end
        3'd3: v = m;
        3'd2: begin
          sh = 8 * (3 - b);
          v = (m << sh) | (rt & ((32'h1 << sh) - 32'h1));
        end
        3'd6: v = (m >> (8*b)) | (rt & ~(32'hFFFF_FFFF >> (8*b)));
        default: v = 32'h0;
      endcase
      e.rdata = v;
    end
    e.lat = 1 + e.nrd + e.nwr;
    return e;
  endfunction

  // Monitor: strobe accounting, response scoreboard and hold-stability checks.
  always @(negedge clk) begin
    if (!reset_n) begin
      in_resp = 1'b0; rd_cnt = 0; wr_cnt = 0;
    end else begin
      check("strobe_mutex", {31'b0, data_read & data_write}, 32'h0);
      if (data_read) rd_cnt++;
      if (data_write) wr_cnt++;
      if (data_read || data_write) check("ram_addr", data_address, exp_addr);
      if (resp_valid) begin
        check("req_ready_busy", {31'b0, req_ready}, 32'h0);
        if (!in_resp) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp: got rdata %h with no request pending", resp_rdata);
          end else begin
            cur = sb_q.pop_front();
            check("rdata", resp_rdata, cur.rdata);
            check("err", {31'b0, resp_err}, {31'b0, cur.err});
            check("latency", cyc - cur.acc + 1, cur.lat);
            check("read_strobes", rd_cnt, cur.nrd);
            check("write_strobes", wr_cnt, cur.nwr);
            if (cur.is_store && !cur.err) check("ram_content", ram[cur.idx], ref_mem[cur.idx]);
          end
          rd_cnt = 0; wr_cnt = 0;
          last_rdata = resp_rdata; last_err = resp_err; in_resp = 1'b1;
        end else begin
          check("rdata_stable", resp_rdata, last_rdata);
          check("err_stable", {31'b0, resp_err}, {31'b0, last_err});
        end
        if (resp_ready) in_resp = 1'b0;
      end
    end
  end

  task automatic issue(input logic w, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rt, input int hold);
    exp_t e;
    int n;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
      return;
    end
    e = model(w, op, addr, wd, rt);
    e.acc = cyc + 1;
    sb_q.push_back(e);
    exp_addr = {addr[31:2], 2'b00};
    req_valid = 1'b1; req_write = w; req_op = op; req_addr = addr; req_wdata = wd; req_rt = rt;
    @(posedge clk); #1;
    // Junk traffic while busy must be ignored.
    req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom_range(0, 1));
    req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom; req_rt = $urandom;
    n = 0;
    while (!resp_valid && n < 10) begin @(posedge clk); #1; n++; end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got 0 expected 1");
      sb_q.delete();
      req_valid = 1'b0;
      return;
    end
    repeat (hold) begin @(posedge clk); #1; end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  logic [31:0] saved;
  int n;

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_op = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rt = 32'h0; resp_ready = 1'b0;
    for (int i = 0; i < 16; i++) ram[i] = $urandom;
    ram[0] = 32'h1234_5678;
    ram[1] = 32'hEEEE_68AC;
    for (int i = 0; i < 16; i++) ref_mem[i] = ram[i];
    repeat (2) begin @(posedge clk); #1; end
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_data_read", {31'b0, data_read}, 32'h0);
    check("rst_data_write", {31'b0, data_write}, 32'h0);
    check("rst_data_address", data_address, 32'h0);
    check("rst_data_writedata", data_writedata, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    issue(1'b0, 3'd3, 32'h4, 32'h0, 32'h0, 5); check("lw_4", last_rdata, 32'hEEEE_68AC);
    issue(1'b0, 3'd0, 32'h7, 32'h0, 32'h0, 0); check("lb_7", last_rdata, 32'hFFFF_FFEE);
    issue(1'b0, 3'd4, 32'h7, 32'h0, 32'h0, 1); check("lbu_7", last_rdata, 32'h0000_00EE);
    issue(1'b0, 3'd1, 32'h6, 32'h0, 32'h0, 0); check("lh_6", last_rdata, 32'hFFFF_EEEE);
    issue(1'b0, 3'd5, 32'h4, 32'h0, 32'h0, 0); check("lhu_4", last_rdata, 32'h0000_68AC);
    issue(1'b1, 3'd0, 32'h1, 32'h0000_00AA, 32'h0, 0); check("sb_ram", ram[0], 32'h1234_AA78);
    issue(1'b0, 3'd3, 32'h0, 32'h0, 32'h0, 0); check("lw_after_sb", last_rdata, 32'h1234_AA78);
    issue(1'b1, 3'd1, 32'h2, 32'h0000_BEEF, 32'h0, 2); check("sh_ram", ram[0], 32'hBEEF_AA78);
    issue(1'b1, 3'd3, 32'h0, 32'h1234_5678, 32'h0, 0); check("sw_ram", ram[0], 32'h1234_5678);
    issue(1'b0, 3'd2, 32'h1, 32'h0, 32'hCAFE_BABE, 0); check("lwl_1", last_rdata, 32'h5678_BABE);
    issue(1'b0, 3'd6, 32'h1, 32'h0, 32'hCAFE_BABE, 0); check("lwr_1", last_rdata, 32'hCA12_3456);
    issue(1'b0, 3'd3, 32'h2, 32'h0, 32'h0, 0); check("lw_2_err", {31'b0, last_err}, 32'h1);
    issue(1'b1, 3'd1, 32'h3, 32'h1111, 32'h0, 0); check("sh_3_err", {31'b0, last_err}, 32'h1);
    issue(1'b1, 3'd5, 32'h8, 32'h2222, 32'h0, 0); check("st101_err", {31'b0, last_err}, 32'h1);

    // Reset during the write cycle of an SB must abort without touching RAM.
    saved = ram[2];
    exp_addr = 32'h8;
    req_valid = 1'b1; req_write = 1'b1; req_op = 3'd0; req_addr = 32'h9; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!data_write && n < 5) begin @(posedge clk); #1; n++; end
    check("rst_saw_write", {31'b0, data_write}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("midrst_data_write", {31'b0, data_write}, 32'h0);
    check("midrst_data_read", {31'b0, data_read}, 32'h0);
    check("midrst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("midrst_req_ready", {31'b0, req_ready}, 32'h1);
    check("midrst_data_address", data_address, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("midrst_ram", ram[2], saved);
    @(posedge clk); #1;
    check("postrst_req_ready", {31'b0, req_ready}, 32'h1);

    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
            $urandom_range(0, 3));
    end
    repeat (3) begin @(posedge clk); #1; end
    check("queue_empty", sb_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
